// File: rtl/pipeline_hazard_sequencer.sv
// rtl/pipeline_hazard_sequencer.sv - per-stage hold/flush sequencing, valid tracking and interrupt drain FSM
//
// Purpose: converts per-register hold/flush requests into per-register enable/clear and the PC enable.
// Tracks one valid bit per pipeline register. When an interrupt is requested, an entry FSM drains
// in-flight instructions, with a bounded timeout, and then takes the trap.
//
// Ports:
//   clk          core clock
//   reset        synchronous active-high reset
//   fetch_valid  fetch presents a valid instruction for R[0]
//   stall_req    bit i: R[i] holds this cycle
//   flush_req    bit i: redirect from stage i, kill R[0..i]
//   irq_req      interrupt pending (level)
//   irq_ack      one-cycle pulse on trap entry
//   pc_en        PC register enable
//   stage_en     per-register enable
//   stage_clr    per-register clear (wins over enable)
//   stage_valid  registered valid bit per register
//   draining     FSM is in DRAIN
//   stall_cycles saturating count of IDLE cycles with pc_en low
module pipeline_hazard_sequencer #(
  parameter int NUM_STAGES = 5,
  parameter int MAX_DRAIN  = 8,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  fetch_valid,
  input  logic [NUM_STAGES-1:0] stall_req,
  input  logic [NUM_STAGES-1:0] flush_req,
  input  logic                  irq_req,
  output logic                  irq_ack,
  output logic                  pc_en,
  output logic [NUM_STAGES-1:0] stage_en,
  output logic [NUM_STAGES-1:0] stage_clr,
  output logic [NUM_STAGES-1:0] stage_valid,
  output logic                  draining,
  output logic [CNT_W-1:0]      stall_cycles
);

  localparam int N  = NUM_STAGES;
  localparam int DW = (MAX_DRAIN > 1) ? $clog2(MAX_DRAIN) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRAIN,
    S_TRAP
  } state_e;

  state_e         state_q, state_d;
  logic [DW-1:0]  cnt_q, cnt_d;
  logic [N-1:0]   valid_q, valid_d;
  logic [CNT_W-1:0] stall_q, stall_d;

  logic [N-1:0] hold;
  logic [N-1:0] kill;
  logic [N-1:0] bubble;
  logic [N-1:0] trap_clr;

  // A stalled register forces every younger register to hold too. A flush kills
  // everything younger than, and including, the redirecting stage.
  always_comb begin
    hold = '0;
    kill = '0;
    hold[N-1] = stall_req[N-1];
    kill[N-1] = flush_req[N-1];
    for (int k = N - 2; k >= 0; k--) begin
      hold[k] = stall_req[k] | hold[k+1];
      kill[k] = flush_req[k] | kill[k+1];
    end
  end

  // Insert a bubble into the first register that advances past a holding one.
  always_comb begin
    bubble = '0;
    for (int k = 0; k < N - 1; k++) begin
      bubble[k+1] = hold[k] & ~hold[k+1];
    end
  end

  // Trap entry discards everything except the oldest register.
  always_comb begin
    trap_clr = '0;
    if (state_q == S_TRAP) begin
      trap_clr[N-2:0] = '1;
    end
  end

  assign stage_en  = ~hold;
  assign stage_clr = kill | bubble | trap_clr;

  // A flush redirects the PC, so fetch is allowed even while R[0] holds.
  assign pc_en = (state_q == S_IDLE) & (~hold[0] | kill[0]);

  // Gated by reset so that a reset landing in TRAP never produces an acknowledge.
  assign irq_ack      = (state_q == S_TRAP) & ~reset;
  assign draining     = (state_q == S_DRAIN);
  assign stage_valid  = valid_q;
  assign stall_cycles = stall_q;

  always_comb begin
    valid_d = valid_q;
    if (stage_clr[0]) begin
      valid_d[0] = 1'b0;
    end else if (stage_en[0]) begin
      valid_d[0] = fetch_valid & pc_en;
    end
    for (int k = 1; k < N; k++) begin
      if (stage_clr[k]) begin
        valid_d[k] = 1'b0;
      end else if (stage_en[k]) begin
        valid_d[k] = valid_q[k-1];
      end
    end
  end

  always_comb begin
    stall_d = stall_q;
    if ((state_q == S_IDLE) && !pc_en && (stall_q != {CNT_W{1'b1}})) begin
      stall_d = stall_q + CNT_W'(1);
    end
  end

  // The drain exit looks at next-cycle valids, so TRAP begins on the first cycle
  // after R[N-2:0] have emptied rather than one cycle later.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (irq_req) begin
          state_d = S_DRAIN;
          cnt_d   = '0;
        end
      end
      S_DRAIN: begin
        cnt_d = cnt_q + DW'(1);
        if (!irq_req) begin
          state_d = S_IDLE;
        end else if ((valid_d[N-2:0] == '0) || (cnt_q == DW'(MAX_DRAIN - 1))) begin
          state_d = S_TRAP;
        end
      end
      S_TRAP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      valid_q <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      stall_q <= stall_d;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_sequencer.sv
// tb/tb_pipeline_hazard_sequencer.sv - directed self-checking bench for pipeline_hazard_sequencer
module tb_pipeline_hazard_sequencer;

  localparam int N  = 5;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          fetch_valid;
  logic [N-1:0]  stall_req;
  logic [N-1:0]  flush_req;
  logic          irq_req;
  logic          irq_ack;
  logic          pc_en;
  logic [N-1:0]  stage_en;
  logic [N-1:0]  stage_clr;
  logic [N-1:0]  stage_valid;
  logic          draining;
  logic [CW-1:0] stall_cycles;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  pipeline_hazard_sequencer #(
    .NUM_STAGES(N),
    .MAX_DRAIN (8),
    .CNT_W     (CW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .fetch_valid (fetch_valid),
    .stall_req   (stall_req),
    .flush_req   (flush_req),
    .irq_req     (irq_req),
    .irq_ack     (irq_ack),
    .pc_en       (pc_en),
    .stage_en    (stage_en),
    .stage_clr   (stage_clr),
    .stage_valid (stage_valid),
    .draining    (draining),
    .stall_cycles(stall_cycles)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset       = 1'b1;
    fetch_valid = 1'b0;
    stall_req   = '0;
    flush_req   = '0;
    irq_req     = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    #1;
  endtask

  task automatic fill();
    fetch_valid = 1'b1;
    repeat (N) tick();
  endtask

  initial begin
    // reset state
    do_reset();
    chk("rst_valid", 32'(stage_valid), 32'h0);
    chk("rst_stall", 32'(stall_cycles), 32'h0);
    chk("rst_ack", 32'(irq_ack), 32'h0);
    chk("rst_drain", 32'(draining), 32'h0);
    chk("rst_pc_en", 32'(pc_en), 32'h1);
    chk("rst_en", 32'(stage_en), 32'h1f);
    chk("rst_clr", 32'(stage_clr), 32'h0);

    // stall in R[2] for 3 cycles
    stall_req = 5'b00100;
    #1;
    chk("stall_en", 32'(stage_en), 32'h18);
    chk("stall_clr", 32'(stage_clr), 32'h08);
    chk("stall_pc_en", 32'(pc_en), 32'h0);
    repeat (3) tick();
    stall_req = '0;
    #1;
    chk("stall_cnt3", 32'(stall_cycles), 32'h3);

    // flush from stage 2 together with a stall in R[1]
    do_reset();
    fill();
    chk("fill_valid", 32'(stage_valid), 32'h1f);
    flush_req = 5'b00100;
    stall_req = 5'b00010;
    #1;
    chk("flush_clr", 32'(stage_clr), 32'h07);
    chk("flush_pc_en", 32'(pc_en), 32'h1);
    tick();
    flush_req = '0;
    stall_req = '0;
    chk("flush_valid", 32'(stage_valid), 32'h18);

    // full pipe, interrupt with no stalls
    do_reset();
    fill();
    irq_req = 1'b1;
    tick();
    for (int i = 1; i <= 4; i++) begin
      chk($sformatf("drain_c%0d", i), 32'(draining), 32'h1);
      chk($sformatf("drain_ack_c%0d", i), 32'(irq_ack), 32'h0);
      chk($sformatf("drain_pc_c%0d", i), 32'(pc_en), 32'h0);
      tick();
    end
    chk("trap_ack", 32'(irq_ack), 32'h1);
    chk("trap_drain", 32'(draining), 32'h0);
    chk("trap_clr", 32'(stage_clr), 32'h0f);
    irq_req = 1'b0;
    tick();
    chk("post_trap_ack", 32'(irq_ack), 32'h0);
    chk("post_trap_pc", 32'(pc_en), 32'h1);
    chk("post_trap_valid", 32'(stage_valid), 32'h0);

    // interrupt with R[4] stalled: drain times out
    do_reset();
    fill();
    stall_req = 5'b10000;
    irq_req   = 1'b1;
    tick();
    for (int i = 1; i <= 8; i++) begin
      chk($sformatf("tmo_drain_c%0d", i), 32'(draining), 32'h1);
      tick();
    end
    chk("tmo_ack", 32'(irq_ack), 32'h1);
    chk("tmo_stall", 32'(stall_cycles), 32'h1);
    irq_req = 1'b0;
    tick();
    chk("tmo_valid", 32'(stage_valid), 32'h10);
    chk("tmo_ack_off", 32'(irq_ack), 32'h0);

    // interrupt withdrawn during DRAIN cycle 2
    do_reset();
    fill();
    irq_req = 1'b1;
    tick();
    chk("wd_c1_ack", 32'(irq_ack), 32'h0);
    tick();
    irq_req = 1'b0;
    #1;
    chk("wd_c2_drain", 32'(draining), 32'h1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("wd_ack_%0d", i), 32'(irq_ack), 32'h0);
      chk($sformatf("wd_drain_%0d", i), 32'(draining), 32'h0);
    end
    chk("wd_pc_en", 32'(pc_en), 32'h1);

    // reset asserted during TRAP
    do_reset();
    fill();
    irq_req = 1'b1;
    repeat (5) tick();
    chk("rt_pre_ack", 32'(irq_ack), 32'h1);
    reset   = 1'b1;
    irq_req = 1'b0;
    #1;
    chk("rt_ack_gated", 32'(irq_ack), 32'h0);
    tick();
    reset = 1'b0;
    #1;
    chk("rt_ack", 32'(irq_ack), 32'h0);
    chk("rt_drain", 32'(draining), 32'h0);
    chk("rt_valid", 32'(stage_valid), 32'h0);

    // stall counter saturation with a 4-bit counter
    do_reset();
    stall_req = 5'b00001;
    repeat (14) tick();
    chk("sat_14", 32'(stall_cycles), 32'he);
    repeat (6) tick();
    chk("sat_20", 32'(stall_cycles), 32'hf);
    stall_req = '0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
